// File: rtl/root_pkg.sv
// Shared constants and state encoding for the Root engine scheduler.
// Results are unsigned Q10.10 and are passed through unmodified.
package root_pkg;

   localparam int INT_W        = 10;
   localparam int FRAC_W       = 10;
   localparam int RES_W        = INT_W + FRAC_W;
   localparam int ORD_W        = 3;
   localparam int FLUSH_CYCLES = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_FLUSH
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid request strictly
// after the pointer, wrapping, and returns it one-hot and encoded.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  idx,
   output logic             valid
);

   always_comb begin
      // NOTE: every output gets a default before the search loop, so no path
      // leaves one unassigned and no latch is inferred.
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!valid && req[(int'(ptr) + k) % N_REQ]) begin
            valid                             = 1'b1;
            grant[(int'(ptr) + k) % N_REQ]    = 1'b1;
            idx                               = ID_W'((int'(ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/root_scheduler.sv
// Shares one iterative Root engine between N_REQ requesters: round-robin grant,
// operand hold, engine issue, watchdog flush and ID-tagged response return.
module root_scheduler
   import root_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [INT_W*N_REQ-1:0]   req_data_1,
   input  logic [ORD_W*N_REQ-1:0]   req_data_2,
   output logic [N_REQ-1:0]         req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [RES_W-1:0]         rsp_data,
   output logic                     rsp_err,
   output logic                     eng_rst_n,
   output logic                     eng_in_valid,
   output logic [INT_W-1:0]         eng_in_data_1,
   output logic [ORD_W-1:0]         eng_in_data_2,
   input  logic                     eng_out_valid,
   input  logic [RES_W-1:0]         eng_out_data,
   output logic                     busy
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   sched_state_t     state;
   logic [ID_W-1:0]  ptr;
   logic [INT_W-1:0] op_1;
   logic [ORD_W-1:0] op_2;
   logic [WD_W-1:0]  wd;
   logic [WD_W-1:0]  wd_inc;
   logic [1:0]       flush_cnt;

   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_any;
   logic [INT_W-1:0] sel_1;
   logic [ORD_W-1:0] sel_2;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx),
      .valid (grant_any)
   );

   assign sel_1         = req_data_1[int'(grant_idx)*INT_W +: INT_W];
   assign sel_2         = req_data_2[int'(grant_idx)*ORD_W +: ORD_W];
   // Grant is only offered while idle and out of reset, so capture happens on this edge.
   assign req_ready     = (state == S_IDLE && rst_n) ? grant : '0;
   assign eng_in_data_1 = op_1;
   assign eng_in_data_2 = op_2;
   // The timeout fires on the WAIT cycle that would bring the watchdog to TIMEOUT.
   assign wd_inc        = wd + WD_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         ptr          <= ID_W'(N_REQ - 1);
         op_1         <= '0;
         op_2         <= '0;
         wd           <= '0;
         flush_cnt    <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         eng_rst_n    <= 1'b0;
         eng_in_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees pre-edge values.
         eng_in_valid <= 1'b0;
         eng_rst_n    <= 1'b1;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  op_1   <= sel_1;
                  op_2   <= sel_2;
                  rsp_id <= grant_idx;
                  ptr    <= grant_idx;
                  busy   <= 1'b1;
                  if (sel_2 == '0) begin
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     eng_in_valid <= 1'b1;
                     state        <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               wd    <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (eng_out_valid) begin
                  rsp_data  <= eng_out_data;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else if (wd_inc == WD_W'(TIMEOUT)) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  flush_cnt <= '0;
                  eng_rst_n <= 1'b0;
                  state     <= S_FLUSH;
               end else begin
                  wd <= wd_inc;
               end
            end
            S_FLUSH: begin
               if (flush_cnt == 2'(FLUSH_CYCLES - 1)) begin
                  rsp_valid <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  eng_rst_n <= 1'b0;
                  flush_cnt <= flush_cnt + 2'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
